// File: rtl/stack_cmd_sequencer.sv
// RPN token sequencer driving a stack unit: one command per token, final value popped on end.
// Latency 3 cycles/token with an immediate response; tok_ready drops while a command is outstanding.
module stack_cmd_sequencer #(
    parameter int          DEPTH   = 8,
    parameter int          TIMEOUT = 15,
    parameter logic [2:0]  OP_PUSH = 3'b101,
    parameter logic [2:0]  OP_ADD  = 3'b011,
    parameter logic [2:0]  OP_POP  = 3'b100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tok_valid,
    output logic       tok_ready,
    input  logic       tok_is_op,
    input  logic       tok_end,
    input  logic [7:0] tok_data,
    output logic [7:0] s_in,
    output logic [2:0] s_op,
    output logic       s_apply,
    input  logic [7:0] s_tail,
    input  logic       s_empty,
    input  logic       s_valid,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       busy
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        REPORT = 3'd3,
        ERR    = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] depth;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [7:0]    in_q;
    logic [7:0]    tail_q;
    logic [7:0]    res_hold;
    logic          end_q;

    always_comb begin
        state_nxt = state;
        tok_ready = 1'b0;
        case (state)
            IDLE: begin
                tok_ready = 1'b1;
                if (tok_valid) begin
                    if (tok_end)
                        state_nxt = (depth == DW'(1)) ? ISSUE : ERR;
                    else if (tok_is_op)
                        state_nxt = (depth >= DW'(2)) ? ISSUE : ERR;
                    else
                        state_nxt = (depth < DW'(DEPTH)) ? ISSUE : ERR;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // a response arriving on the last counted cycle still wins over the timeout
                if (s_valid) begin
                    if (op_q == OP_POP)
                        state_nxt = s_empty ? ERR : REPORT;
                    else
                        state_nxt = IDLE;
                end else if (cnt == CW'(TIMEOUT)) begin
                    state_nxt = ERR;
                end
            end
            REPORT: state_nxt = IDLE;
            ERR:    state_nxt = end_q ? IDLE : DRAIN;
            DRAIN: begin
                tok_ready = 1'b1;
                if (tok_valid && tok_end)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst)
            tok_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            depth    <= '0;
            cnt      <= '0;
            op_q     <= 3'b000;
            in_q     <= 8'h00;
            tail_q   <= 8'h00;
            res_hold <= 8'h00;
            end_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (tok_valid) begin
                        end_q <= tok_end;
                        if (state_nxt == ISSUE) begin
                            if (tok_end) begin
                                op_q <= OP_POP;
                            end else if (tok_is_op) begin
                                op_q <= OP_ADD;
                            end else begin
                                op_q <= OP_PUSH;
                                in_q <= tok_data;
                            end
                        end
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (s_valid) begin
                        if (op_q == OP_PUSH) begin
                            depth <= depth + DW'(1);
                        end else begin
                            depth <= depth - DW'(1);
                            if (op_q == OP_POP)
                                tail_q <= s_tail;
                        end
                    end else if (cnt != CW'(TIMEOUT)) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                REPORT: begin
                    depth    <= '0;
                    res_hold <= tail_q;
                end
                ERR: res_hold <= 8'h00;
                default: ;
            endcase
            if (state_nxt == ERR)
                depth <= '0;
        end
    end

    assign s_op      = op_q;
    assign s_in      = in_q;
    assign s_apply   = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == REPORT) || (state == ERR);
    assign res_err   = (state == ERR);
    assign res_data  = (state == REPORT) ? tail_q :
                       (state == ERR)    ? 8'h00  : res_hold;

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Scoreboard bench for stack_cmd_sequencer with a behavioural stack-unit model.
module tb_stack_cmd_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 15;
    localparam logic [2:0] OP_PUSH = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_POP  = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic       tok_is_op = 1'b0;
    logic       tok_end = 1'b0;
    logic [7:0] tok_data = 8'h00;
    logic [7:0] s_in;
    logic [2:0] s_op;
    logic       s_apply;
    logic [7:0] s_tail = 8'h00;
    logic       s_empty = 1'b1;
    logic       s_valid = 1'b0;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_err;
    logic       busy;

    always #5 clk = ~clk;

    stack_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
        .tok_end(tok_end), .tok_data(tok_data),
        .s_in(s_in), .s_op(s_op), .s_apply(s_apply),
        .s_tail(s_tail), .s_empty(s_empty), .s_valid(s_valid),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    int apply_cnt = 0;

    typedef struct { logic err; logic [7:0] data; } res_t;
    typedef struct { logic [2:0] op; logic [7:0] din; bit chk_in; } cmd_t;
    res_t exp_res[$];
    cmd_t exp_cmd[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stack-unit model: s_empty on a response reports whether the stack was empty
    // when the command arrived, so a POP from an empty stack flags the mismatch.
    logic [7:0] stk [0:15];
    int         sp = 0;
    bit         pend = 0;
    int         wait_n = 0;
    int         resp_dly = 0;
    bit         mute = 0;
    logic [2:0] l_op = 3'b000;
    logic [7:0] l_in = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            sp = 0; pend = 0; s_valid = 1'b0; s_tail = 8'h00; s_empty = 1'b1;
        end else begin
            if (s_valid) s_valid = 1'b0;
            if (pend) begin
                if (wait_n == 0) begin
                    s_empty = (sp == 0);
                    case (l_op)
                        OP_PUSH: begin stk[sp] = l_in; sp++; s_tail = l_in; end
                        OP_ADD: if (sp >= 2) begin
                            stk[sp-2] = stk[sp-2] + stk[sp-1]; sp--; s_tail = stk[sp-1];
                        end
                        OP_POP: if (sp > 0) begin sp--; s_tail = stk[sp]; end
                                else s_tail = 8'h00;
                        default: ;
                    endcase
                    s_valid = 1'b1;
                    pend = 0;
                end else begin
                    wait_n--;
                end
            end
            if (s_apply && !mute) begin
                pend = 1; wait_n = resp_dly; l_op = s_op; l_in = s_in;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (s_apply) begin
                cmd_t c;
                apply_cnt++;
                if (exp_cmd.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_apply: got op %0d expected none", s_op);
                end else begin
                    c = exp_cmd.pop_front();
                    check("cmd_op", 32'(s_op), 32'(c.op));
                    if (c.chk_in) check("cmd_in", 32'(s_in), 32'(c.din));
                end
            end
            if (res_valid) begin
                res_t r;
                if (exp_res.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_result: got err %0d data %0d expected none", res_err, res_data);
                end else begin
                    r = exp_res.pop_front();
                    check("res_err", 32'(res_err), 32'(r.err));
                    check("res_data", 32'(res_data), 32'(r.data));
                end
            end
        end
    end

    task automatic send(input bit is_op, input bit e, input logic [7:0] d);
        int n;
        @(negedge clk);
        tok_valid = 1'b1; tok_is_op = is_op; tok_end = e; tok_data = d;
        n = 0;
        while (!tok_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) begin
            tests++; fails++;
            $display("FAIL token_accept: got no tok_ready expected handshake within 300 cycles");
        end else begin
            @(posedge clk);
        end
        #1 tok_valid = 1'b0;
    endtask

    task automatic operand(input logic [7:0] d);
        exp_cmd.push_back('{op: OP_PUSH, din: d, chk_in: 1'b1});
        send(1'b0, 1'b0, d);
    endtask

    task automatic add_tok();
        exp_cmd.push_back('{op: OP_ADD, din: 8'h00, chk_in: 1'b0});
        send(1'b1, 1'b0, 8'h00);
    endtask

    task automatic end_tok();
        exp_cmd.push_back('{op: OP_POP, din: 8'h00, chk_in: 1'b0});
        send(1'b0, 1'b1, 8'h00);
    endtask

    task automatic expect_res(input logic err, input logic [7:0] d);
        exp_res.push_back('{err: err, data: d});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_res.size() != 0 || exp_cmd.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("settle", 32'(n < 400), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tok_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tok_ready"}, 32'(tok_ready), 32'd0);
        check({tag, "_s_apply"},   32'(s_apply),   32'd0);
        check({tag, "_s_op"},      32'(s_op),      32'd0);
        check({tag, "_s_in"},      32'(s_in),      32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_data"},  32'(res_data),  32'd0);
        check({tag, "_res_err"},   32'(res_err),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        int base;
        int n;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(tok_ready), 32'd1);

        // 2 4 + -> 6
        expect_res(1'b0, 8'd6);
        operand(8'd2); operand(8'd4); add_tok(); end_tok();
        wait_idle();
        check("res_hold", 32'(res_data), 32'd6);

        // 200 100 + -> 44 (mod 256)
        expect_res(1'b0, 8'd44);
        operand(8'd200); operand(8'd100); add_tok(); end_tok();
        wait_idle();

        // operator at empty stack: error, no apply, drain up to end, then recover
        base = apply_cnt;
        expect_res(1'b1, 8'd0);
        send(1'b1, 1'b0, 8'h00);
        send(1'b0, 1'b0, 8'd1);
        send(1'b0, 1'b0, 8'd2);
        send(1'b0, 1'b1, 8'h00);
        wait_idle();
        check("drain_no_apply", 32'(apply_cnt - base), 32'd0);
        expect_res(1'b0, 8'd3);
        operand(8'd3); end_tok();
        wait_idle();

        // overflow: DEPTH pushes accepted, the next operand errors
        do_reset();
        base = apply_cnt;
        for (int i = 0; i < DEPTH; i++) operand(8'(10 + i));
        expect_res(1'b1, 8'd0);
        send(1'b0, 1'b0, 8'd99);
        send(1'b0, 1'b1, 8'h00);
        wait_idle();
        check("overflow_applies", 32'(apply_cnt - base), 32'(DEPTH));

        // silent stack unit: timeout error, busy held through drain
        do_reset();
        mute = 1;
        exp_cmd.push_back('{op: OP_PUSH, din: 8'd7, chk_in: 1'b1});
        expect_res(1'b1, 8'd0);
        send(1'b0, 1'b0, 8'd7);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 100);
        check("timeout_window", 32'(n >= TIMEOUT + 2 && n <= TIMEOUT + 4), 32'd1);
        check("busy_in_err", 32'(busy), 32'd1);
        mute = 0;
        send(1'b0, 1'b1, 8'h00);
        wait_idle();
        check("busy_after_drain", 32'(busy), 32'd0);

        // response on the last counted wait cycle is still a response
        do_reset();
        resp_dly = TIMEOUT;
        expect_res(1'b0, 8'd9);
        operand(8'd9); end_tok();
        wait_idle();
        resp_dly = 0;

        // reset while waiting abandons the command silently
        do_reset();
        resp_dly = 4;
        exp_cmd.push_back('{op: OP_PUSH, din: 8'd7, chk_in: 1'b1});
        send(1'b0, 1'b0, 8'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        resp_dly = 0;
        expect_res(1'b0, 8'd5);
        operand(8'd5); end_tok();
        wait_idle();

        check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        check("res_queue_empty", 32'(exp_res.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
